// File: rtl/halut_pkg.sv
// halut_pkg: shared sizes, FSM state type and threshold-write record for the HALUT encoder controller.
package halut_pkg;
   localparam int K                  = 16;
   localparam int C                  = 32;
   localparam int EncUnits           = 4;
   localparam int DataTypeWidth      = 16;
   localparam int TreeDepth          = $clog2(K);
   localparam int CPerEncUnit        = C / EncUnits;
   localparam int ThreshMemAddrWidth = $clog2(CPerEncUnit * K);
   localparam int UnitIdxWidth       = EncUnits > 1 ? $clog2(EncUnits) : 1;
   localparam int LevelWidth         = TreeDepth > 1 ? $clog2(TreeDepth) : 1;
   localparam int CIdxWidth          = CPerEncUnit > 1 ? $clog2(CPerEncUnit) : 1;

   typedef enum logic [1:0] {IDLE, ENCODE, DRAIN} enc_ctrl_state_e;

   typedef struct packed {
      logic [UnitIdxWidth-1:0]       unit;
      logic [ThreshMemAddrWidth-1:0] addr;
      logic [DataTypeWidth-1:0]      data;
   } thresh_wr_t;
endpackage

// File: rtl/halut_cfg_router.sv
// halut_cfg_router: registers one accepted threshold write and steers it to a single encoder unit.
module halut_cfg_router
   import halut_pkg::*;
(
   input  logic                          clk_i,
   input  logic                          rst_ni,
   input  logic                          wr_valid_i,
   input  thresh_wr_t                    wr_i,
   output logic [EncUnits-1:0]           we_o,
   output logic [ThreshMemAddrWidth-1:0] waddr_o,
   output logic [DataTypeWidth-1:0]      wdata_o
);
   localparam int UnitSpan = 1 << UnitIdxWidth;

   // Decoding over the full index span drops out-of-range units for free.
   logic [UnitSpan-1:0]           dec;
   logic [EncUnits-1:0]           we_q;
   logic [ThreshMemAddrWidth-1:0] waddr_q;
   logic [DataTypeWidth-1:0]      wdata_q;

   assign dec = UnitSpan'(1) << wr_i.unit;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         we_q    <= '0;
         waddr_q <= '0;
         wdata_q <= '0;
      end else begin
         we_q <= wr_valid_i ? dec[EncUnits-1:0] : '0;
         if (wr_valid_i) begin
            waddr_q <= wr_i.addr;
            wdata_q <= wr_i.data;
         end
      end
   end

   assign we_o    = we_q;
   assign waddr_o = waddr_q;
   assign wdata_o = wdata_q;
endmodule

// File: rtl/halut_encoder_ctrl.sv
// halut_encoder_ctrl: row/level/codebook sequencer and threshold-write router for the encoder bank.
// HALUT_ENCODER_CTRL_PERF_EN adds row and stall counters; otherwise the perf ports read 0.
module halut_encoder_ctrl
   import halut_pkg::*;
(
   input  logic                          clk_i,
   input  logic                          rst_ni,
   input  logic                          row_valid_i,
   output logic                          row_ready_o,
   input  logic                          cfg_valid_i,
   output logic                          cfg_ready_o,
   input  logic [UnitIdxWidth-1:0]       cfg_unit_i,
   input  logic [ThreshMemAddrWidth-1:0] cfg_addr_i,
   input  logic [DataTypeWidth-1:0]      cfg_data_i,
   output logic [EncUnits-1:0]           we_o,
   output logic [ThreshMemAddrWidth-1:0] waddr_o,
   output logic [DataTypeWidth-1:0]      wdata_o,
   output logic                          encoder_en_o,
   output logic [LevelWidth-1:0]         tree_level_o,
   output logic [CIdxWidth-1:0]          c_idx_o,
   output logic                          row_done_o,
   output logic                          busy_o,
   output logic [31:0]                   perf_rows_o,
   output logic [31:0]                   perf_stall_o
);
   enc_ctrl_state_e       state_q, state_d;
   logic [LevelWidth-1:0] level_q, level_d;
   logic [CIdxWidth-1:0]  cidx_q, cidx_d;
   logic                  idle, encoding, row_hs, cfg_hs, level_wrap, last;
   thresh_wr_t            wr;

   assign idle        = state_q == IDLE;
   assign encoding    = state_q == ENCODE;
   assign cfg_ready_o = idle;
   assign row_ready_o = idle && !cfg_valid_i;
   assign row_hs      = row_valid_i && row_ready_o;
   assign cfg_hs      = cfg_valid_i && cfg_ready_o;
   assign level_wrap  = level_q == LevelWidth'(TreeDepth - 1);
   assign last        = level_wrap && cidx_q == CIdxWidth'(CPerEncUnit - 1);

   // Counters sit at 0 outside ENCODE so they track each unit's own counters.
   always_comb begin
      state_d = idle ? (row_hs ? ENCODE : IDLE) : encoding ? (last ? DRAIN : ENCODE) : IDLE;
      level_d = encoding && !level_wrap ? level_q + 1'b1 : '0;
      cidx_d  = encoding && !last ? cidx_q + CIdxWidth'(level_wrap) : '0;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= IDLE;
         level_q <= '0;
         cidx_q  <= '0;
      end else begin
         state_q <= state_d;
         level_q <= level_d;
         cidx_q  <= cidx_d;
      end
   end

   assign encoder_en_o = encoding;
   assign row_done_o   = state_q == DRAIN;
   assign busy_o       = !idle;
   assign tree_level_o = level_q;
   assign c_idx_o      = cidx_q;
   assign wr           = '{unit: cfg_unit_i, addr: cfg_addr_i, data: cfg_data_i};

   halut_cfg_router u_cfg_router (
      .clk_i      (clk_i),
      .rst_ni     (rst_ni),
      .wr_valid_i (cfg_hs),
      .wr_i       (wr),
      .we_o       (we_o),
      .waddr_o    (waddr_o),
      .wdata_o    (wdata_o)
   );

`ifdef HALUT_ENCODER_CTRL_PERF_EN
   logic [31:0] rows_q, stall_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rows_q  <= '0;
         stall_q <= '0;
      end else begin
         if (row_done_o) rows_q <= rows_q + 32'd1;
         if (row_valid_i && !row_ready_o) stall_q <= stall_q + 32'd1;
      end
   end

   assign perf_rows_o  = rows_q;
   assign perf_stall_o = stall_q;
`else
   assign perf_rows_o  = '0;
   assign perf_stall_o = '0;
`endif
endmodule

// File: tb/tb_halut_encoder_ctrl.sv
// tb_halut_encoder_ctrl: randomized and directed stimulus against a cycle-stamped event scoreboard.
module tb_halut_encoder_ctrl;
   import halut_pkg::*;

   localparam int N = CPerEncUnit * TreeDepth;

   logic clk = 0, rst_ni = 0;
   logic row_valid_i = 0, cfg_valid_i = 0;
   logic row_ready_o, cfg_ready_o;
   logic [UnitIdxWidth-1:0] cfg_unit_i = '0;
   logic [ThreshMemAddrWidth-1:0] cfg_addr_i = '0;
   logic [DataTypeWidth-1:0] cfg_data_i = '0;
   logic [EncUnits-1:0] we_o;
   logic [ThreshMemAddrWidth-1:0] waddr_o;
   logic [DataTypeWidth-1:0] wdata_o;
   logic encoder_en_o, row_done_o, busy_o;
   logic [LevelWidth-1:0] tree_level_o;
   logic [CIdxWidth-1:0] c_idx_o;
   logic [31:0] perf_rows_o, perf_stall_o;

   halut_encoder_ctrl dut (
      .clk_i(clk), .rst_ni(rst_ni),
      .row_valid_i(row_valid_i), .row_ready_o(row_ready_o),
      .cfg_valid_i(cfg_valid_i), .cfg_ready_o(cfg_ready_o),
      .cfg_unit_i(cfg_unit_i), .cfg_addr_i(cfg_addr_i), .cfg_data_i(cfg_data_i),
      .we_o(we_o), .waddr_o(waddr_o), .wdata_o(wdata_o),
      .encoder_en_o(encoder_en_o), .tree_level_o(tree_level_o), .c_idx_o(c_idx_o),
      .row_done_o(row_done_o), .busy_o(busy_o),
      .perf_rows_o(perf_rows_o), .perf_stall_o(perf_stall_o)
   );

   always #5 clk = ~clk;

   // kind: 0 = threshold write, 1 = encode beat, 2 = row done
   typedef struct {
      int   cyc;
      int   kind;
      logic [EncUnits-1:0] we;
      logic [ThreshMemAddrWidth-1:0] addr;
      logic [DataTypeWidth-1:0] data;
      int   lvl;
      int   cidx;
   } ev_t;

   ev_t q[$];
   int cyc = 0;
   int n_checks = 0, n_fail = 0;
   int busy_until = 0;
   int rows_m = 0, stall_m = 0;
   int rows_accepted = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic step(input bit rv, input bit cv, input int unit, input int addr, input int data);
      int t;
      bit idle_m, rrdy_m;
      logic [31:0] exp_rows, exp_stall;
      ev_t e;
      @(posedge clk);
      #1;
      row_valid_i = rv;
      cfg_valid_i = cv;
      cfg_unit_i  = UnitIdxWidth'(unit);
      cfg_addr_i  = ThreshMemAddrWidth'(addr);
      cfg_data_i  = DataTypeWidth'(data);
      #1;
      t = cyc;
      idle_m = t >= busy_until;
      rrdy_m = idle_m && !cv;
      n_checks++;
      if (cfg_ready_o !== idle_m || row_ready_o !== rrdy_m) begin
         n_fail++;
         $display("FAIL ready cyc=%0d got cfg=%b row=%b exp cfg=%b row=%b", t, cfg_ready_o, row_ready_o, idle_m, rrdy_m);
      end
`ifdef HALUT_ENCODER_CTRL_PERF_EN
      exp_rows = 32'(rows_m);
      exp_stall = 32'(stall_m);
`else
      exp_rows = 0;
      exp_stall = 0;
`endif
      n_checks++;
      if (perf_rows_o !== exp_rows || perf_stall_o !== exp_stall) begin
         n_fail++;
         $display("FAIL perf cyc=%0d got rows=%0d stall=%0d exp rows=%0d stall=%0d", t, perf_rows_o, perf_stall_o, exp_rows, exp_stall);
      end
      if (busy_until != 0 && t == busy_until - 1) rows_m++;
      if (rv && !rrdy_m) stall_m++;
      if (cv && idle_m) begin
         e = '{cyc: t + 1, kind: 0, we: EncUnits'(1) << unit, addr: ThreshMemAddrWidth'(addr),
               data: DataTypeWidth'(data), lvl: 0, cidx: 0};
         q.push_back(e);
      end else if (rv && idle_m) begin
         for (int i = 0; i < N; i++) begin
            e = '{cyc: t + 1 + i, kind: 1, we: '0, addr: '0, data: '0, lvl: i % TreeDepth, cidx: i / TreeDepth};
            q.push_back(e);
         end
         e = '{cyc: t + N + 1, kind: 2, we: '0, addr: '0, data: '0, lvl: 0, cidx: 0};
         q.push_back(e);
         busy_until = t + N + 2;
         rows_accepted++;
      end
   endtask

   task automatic idle_steps(input int n);
      repeat (n) step(0, 0, 0, 0, 0);
   endtask

   task automatic do_reset();
      @(posedge clk);
      #1;
      rst_ni = 0;
      row_valid_i = 0;
      cfg_valid_i = 0;
      q.delete();
      busy_until = 0;
      rows_m = 0;
      stall_m = 0;
      repeat (3) @(posedge clk);
      #1;
      rst_ni = 1;
   endtask

   always @(negedge clk) begin
      bit present, exp_present, ok;
      ev_t e;
      if (!rst_ni) begin
         n_checks++;
         if (we_o !== '0 || encoder_en_o !== 0 || row_done_o !== 0 || busy_o !== 0 || tree_level_o !== '0 ||
             c_idx_o !== '0 || waddr_o !== '0 || wdata_o !== '0 || cfg_ready_o !== 1 || row_ready_o !== 1 ||
             perf_rows_o !== '0 || perf_stall_o !== '0) begin
            n_fail++;
            $display("FAIL reset_state cyc=%0d we=%b en=%b done=%b busy=%b lvl=%0d cidx=%0d exp all 0 with readies 1",
                     cyc, we_o, encoder_en_o, row_done_o, busy_o, tree_level_o, c_idx_o);
         end
      end else begin
         present = we_o != '0 || encoder_en_o || row_done_o;
         while (q.size() != 0 && q[0].cyc < cyc) begin
            n_checks++;
            n_fail++;
            $display("FAIL missing_event cyc=%0d got nothing exp kind=%0d at cyc=%0d", cyc, q[0].kind, q[0].cyc);
            void'(q.pop_front());
         end
         exp_present = q.size() != 0 && q[0].cyc == cyc;
         n_checks++;
         if (encoder_en_o && we_o != '0) begin
            n_fail++;
            $display("FAIL en_we_overlap cyc=%0d got en=1 we=%b exp we=0", cyc, we_o);
         end
         n_checks++;
         if (present != exp_present || busy_o !== (exp_present && q[0].kind != 0)) begin
            n_fail++;
            $display("FAIL presence cyc=%0d got out=%b busy=%b exp out=%b", cyc, present, busy_o, exp_present);
         end else if (present) begin
            e = q.pop_front();
            ok = we_o === e.we && encoder_en_o === (e.kind == 1) && row_done_o === (e.kind == 2);
            if (e.kind == 0) ok = ok && waddr_o === e.addr && wdata_o === e.data;
            if (e.kind == 1) ok = ok && int'(tree_level_o) == e.lvl && int'(c_idx_o) == e.cidx;
            n_checks++;
            if (!ok) begin
               n_fail++;
               $display("FAIL event cyc=%0d got we=%b addr=%h data=%h en=%b lvl=%0d cidx=%0d done=%b exp kind=%0d we=%b addr=%h data=%h lvl=%0d cidx=%0d",
                        cyc, we_o, waddr_o, wdata_o, encoder_en_o, tree_level_o, c_idx_o, row_done_o,
                        e.kind, e.we, e.addr, e.data, e.lvl, e.cidx);
            end
         end
      end
   end

   initial begin
      int target;
      repeat (3) @(posedge clk);
      #1;
      rst_ni = 1;
      // single threshold write
      step(0, 1, 2, 'h05, 'h3C00);
      idle_steps(3);
      // single row
      step(1, 0, 0, 0, 0);
      idle_steps(N + 2);
      // row and cfg together: cfg wins, row follows
      step(1, 1, 1, 'h07, 'h1234);
      step(1, 0, 0, 0, 0);
      idle_steps(N + 2);
      // cfg raised mid-encode waits for IDLE, then back-to-back writes
      step(1, 0, 0, 0, 0);
      idle_steps(9);
      for (int i = 0; i < 26; i++) step(0, 1, 3, 'h09 + i, 'hBEE0 + i);
      idle_steps(2);
      // reset mid-encode, then restart from level 0 / codebook 0
      step(1, 0, 0, 0, 0);
      idle_steps(14);
      do_reset();
      step(1, 0, 0, 0, 0);
      idle_steps(N + 2);
      // three rows with row_valid held high
      target = rows_accepted + 3;
      for (int i = 0; i < 200 && rows_accepted < target; i++) step(1, 0, 0, 0, 0);
      idle_steps(N + 2);
      // randomized traffic
      for (int i = 0; i < 700; i++)
         step($urandom_range(0, 1) == 1, $urandom_range(0, 7) == 0, $urandom_range(0, EncUnits - 1),
              $urandom_range(0, (1 << ThreshMemAddrWidth) - 1), $urandom_range(0, 65535));
      idle_steps(N + 4);
      n_checks++;
      if (q.size() != 0) begin
         n_fail++;
         $display("FAIL drain got %0d pending events exp 0", q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
